tlp_tx_arbiter: RTL and testbench
=================================

Name: tlp_tx_arbiter

Overview:
Round-robin scheduler that shares one 8-bit framed TLP lane between N_REQ requesters. Each requester presents an 18-byte TLP body. The block grants one requester and latches its body. It then serialises the frame as STP, 18 body bytes, END, followed by idle filler. It sits upstream of the receive-side TLP detector and its decoder, and feeds the byte stream they consume.

Parameters:
N_REQ, 4, number of requesters (2..8)
BODY_BYTES, 18, body bytes per frame (fixed frame = BODY_BYTES+2 bytes)
GAP, 1, extra idle cycles after END before re-arbitration (0..15)
IDLE_BYTE, 8'h00, filler byte driven when no frame is active

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester "TLP pending" level
tlp_body  in  N_REQ*BODY_BYTES*8  requester i body at [i*144 +: 144]; byte k = [8k+7:8k]
gnt  out  N_REQ  one-hot, one-cycle pulse: body of that requester latched
data_out  out  8  serial lane byte
data_k  out  1  high on STP/END control bytes only
busy  out  1  high from STP cycle through last GAP cycle
frame_count  out  4  frames completed, wraps 15->0

Behaviour:
- All outputs are registered. On reset: state IDLE, data_out=IDLE_BYTE, data_k=0, gnt=0, busy=0, frame_count=0, rr_ptr=N_REQ-1 (requester 0 wins first).
- The FSM has five states: IDLE, SOF, BODY, EOF, GAP.
- IDLE:
  - data_out=IDLE_BYTE, data_k=0.
  - If any req is high at the edge, the winner is chosen by round-robin, searching from rr_ptr+1 upward with wrap.
  - On that edge: latch the winner's body, set gnt[w]=1, set rr_ptr=w, go to SOF.
- SOF: data_out=8'hFB, data_k=1, busy=1, gnt[w] high in this cycle only. Go to BODY with byte_cnt=0.
- BODY:
  - data_out = latched byte byte_cnt, starting at byte 0 (LSB byte); data_k=0.
  - byte_cnt is 5-bit and increments each cycle.
  - After byte BODY_BYTES-1, go to EOF.
- EOF: data_out=8'hFD, data_k=1, frame_count += 1 (registered, visible the next cycle). Go to GAP if GAP>0, else IDLE.
- GAP: data_out=IDLE_BYTE, busy=1, counts GAP cycles, then goes to IDLE.
- Timing, for req sampled at edge t:
  - STP is on the lane in cycle t+1.
  - Body occupies cycles t+2..t+19.
  - END is in cycle t+20.
  - The next STP comes no earlier than t+22+GAP (one IDLE arbitration cycle always exists).
- Requester handshake:
  - Hold req and tlp_body stable until gnt is seen.
  - Deassert req, or present the next body, in the cycle after gnt.
  - Dropping req before grant is legal; that requester is skipped.
- Only the latched copy of the body is transmitted. tlp_body changes after grant have no effect on the frame in flight.
- req changes during SOF..GAP are ignored until IDLE.
- Simultaneous requests: exactly one gnt bit is ever high. No requester starves; with all req high, the grant order is 0,1,2,3,0,...
- Reset mid-frame takes effect at the next edge: the lane returns to IDLE_BYTE and no END is sent. The partial frame is abandoned, with no frame_count increment and rr_ptr back to N_REQ-1.
- frame_count wraps silently.

Optional Feature:
TLP_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round-robin as above.
- All timing and handshake rules are unchanged in both modes.

Decomposition:
- Package tlp_pkg holds:
  - STP=8'hFB, END=8'hFD
  - BODY_BYTES=18 and the derived body width of 144
  - the FSM state encoding (IDLE/SOF/BODY/EOF/GAP)
- One sub-module, tlp_rr_arbiter: inputs req and rr_ptr; outputs a one-hot winner and its index. It contains the TLP_ARB_FIXED_PRIO_EN switch.
- Body latching and the byte mux stay in the top module.

Test Plan:
- Single request: req=4'b0001 at edge t, body bytes 0x01..0x12. Expect gnt=0001 in t+1, FB in t+1, 01..12 in t+2..t+19, FD in t+20, frame_count 0->1 visible in t+21.
- All requesters held high for 8 frames. Expect grant order 0,1,2,3,0,1,2,3, exactly one gnt bit per frame, frame_count=8.
- With TLP_ARB_FIXED_PRIO_EN: req=1010 held. Expect every grant goes to requester 1; requester 3 is never granted while req[1] is high.
- Reset asserted at body byte 7. Expect IDLE_BYTE on the next cycle, no FD, frame_count unchanged, and a subsequent req=1000 granted normally.
- GAP=0 and GAP=3, with req held high continuously. Expect END-to-next-STP spacing of 2 and 5 cycles, with idle bytes in between and data_k=0.
- 17 back-to-back frames. Expect frame_count to wrap 15->0->1.

Source files
------------

// File: rtl/tlp_tx_arbiter_pkg.sv
// Shared constants, framing bytes and FSM state encoding for the TLP transmit arbiter.
package tlp_pkg;

    localparam logic [7:0] STP        = 8'hFB;
    localparam logic [7:0] END        = 8'hFD;
    localparam int         BODY_BYTES = 18;
    localparam int         BODY_W     = BODY_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_BODY = 3'd2,
        ST_EOF  = 3'd3,
        ST_GAP  = 3'd4
    } tlp_state_e;

endpackage

// File: rtl/tlp_tx_arbiter_rr_arbiter.sv
// Picks one pending requester: round-robin after rr_ptr_i, or lowest index when
// TLP_ARB_FIXED_PRIO_EN is defined (rr_ptr_i is then ignored).
module tlp_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    rr_ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PW-1:0]    grant_idx_o,
    output logic             valid_o
);

`ifdef TLP_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr_i;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = |req_i;
        // Descending scan so the lowest pending index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) grant_idx_o = PW'(i);
        end
        if (valid_o) grant_o[grant_idx_o] = 1'b1;
    end
`else
    int cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        cand        = 0;
        // Search starts one past the last winner and wraps.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(rr_ptr_i) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!valid_o && req_i[PW'(cand)]) begin
                valid_o     = 1'b1;
                grant_idx_o = PW'(cand);
            end
        end
        if (valid_o) grant_o[grant_idx_o] = 1'b1;
    end
`endif

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Shares one framed 8-bit TLP lane between N_REQ requesters: STP, body, END, idle filler.
// Define TLP_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module tlp_tx_arbiter
    import tlp_pkg::*;
#(
    parameter int         N_REQ     = 4,
    parameter int         GAP       = 1,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BODY_W-1:0]  tlp_body,
    output logic [N_REQ-1:0]         gnt,
    output logic [7:0]               data_out,
    output logic                     data_k,
    output logic                     busy,
    output logic [3:0]               frame_count,
    output tlp_state_e               dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tlp_state_e                       state_q, state_d;
    logic [4:0]                       byte_cnt_q, byte_cnt_d;
    logic [3:0]                       gap_cnt_q, gap_cnt_d;
    logic [BODY_BYTES-1:0][7:0]       body_q, body_d;
    logic [7:0]                       data_q, data_d;
    logic                             k_q, k_d;
    logic                             busy_q, busy_d;
    logic [N_REQ-1:0]                 gnt_q, gnt_d;
    logic [3:0]                       fc_q, fc_d;

    logic [N_REQ-1:0][BODY_W-1:0]     bodies;
    logic [N_REQ-1:0]                 win_oh;
    logic [PW-1:0]                    win_idx;
    logic                             win_vld;
    logic [PW-1:0]                    arb_ptr;

    assign bodies = tlp_body;

`ifdef TLP_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    assign arb_ptr = rr_ptr_q;
`endif

    tlp_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req_i       (req),
        .rr_ptr_i    (arb_ptr),
        .grant_o     (win_oh),
        .grant_idx_o (win_idx),
        .valid_o     (win_vld)
    );

    // The *_d values are what the lane shows next cycle, so every output is a flop.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        body_d     = body_q;
        data_d     = IDLE_BYTE;
        k_d        = 1'b0;
        busy_d     = 1'b0;
        gnt_d      = '0;
        fc_d       = fc_q;
`ifndef TLP_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d  = ST_SOF;
                    body_d   = bodies[win_idx];
                    gnt_d    = win_oh;
                    data_d   = STP;
                    k_d      = 1'b1;
                    busy_d   = 1'b1;
`ifndef TLP_ARB_FIXED_PRIO_EN
                    rr_ptr_d = win_idx;
`endif
                end
            end
            ST_SOF: begin
                state_d    = ST_BODY;
                byte_cnt_d = '0;
                data_d     = body_q[0];
                busy_d     = 1'b1;
            end
            ST_BODY: begin
                busy_d = 1'b1;
                if (byte_cnt_q == 5'(BODY_BYTES - 1)) begin
                    state_d = ST_EOF;
                    data_d  = END;
                    k_d     = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    data_d     = body_q[byte_cnt_d];
                end
            end
            ST_EOF: begin
                fc_d = fc_q + 4'd1;
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = 4'd1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                    busy_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            body_q     <= '0;
            data_q     <= IDLE_BYTE;
            k_q        <= 1'b0;
            busy_q     <= 1'b0;
            gnt_q      <= '0;
            fc_q       <= '0;
`ifndef TLP_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= PW'(N_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            body_q     <= body_d;
            data_q     <= data_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            fc_q       <= fc_d;
`ifndef TLP_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign data_out    = data_q;
    assign data_k      = k_q;
    assign busy        = busy_q;
    assign frame_count = fc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Bench for tlp_tx_arbiter: three instances (GAP=1,0,3) share stimulus and are checked
// every cycle against a frame-position model, plus literal checks on key cycles.
module tb_tlp_tx_arbiter;
    import tlp_pkg::*;

    localparam int         N      = 4;
    localparam int         NB     = BODY_BYTES;
    localparam int         NI     = 3;
    localparam logic [7:0] IDLE_B = 8'h00;

    logic                  clk      = 1'b0;
    logic                  reset    = 1'b1;
    logic [N-1:0]          req      = '0;
    logic [N*NB*8-1:0]     tlp_body = '0;

    logic [N-1:0]          gnt_w  [NI];
    logic [7:0]            data_w [NI];
    logic                  k_w    [NI];
    logic                  busy_w [NI];
    logic [3:0]            fc_w   [NI];
    tlp_state_e            st_w   [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tlp_tx_arbiter #(.N_REQ(N), .GAP(1), .IDLE_BYTE(IDLE_B)) dut (
        .clk(clk), .reset(reset), .req(req), .tlp_body(tlp_body),
        .gnt(gnt_w[0]), .data_out(data_w[0]), .data_k(k_w[0]), .busy(busy_w[0]),
        .frame_count(fc_w[0]), .dbg_state(st_w[0]));

    tlp_tx_arbiter #(.N_REQ(N), .GAP(0), .IDLE_BYTE(IDLE_B)) dut_g0 (
        .clk(clk), .reset(reset), .req(req), .tlp_body(tlp_body),
        .gnt(gnt_w[1]), .data_out(data_w[1]), .data_k(k_w[1]), .busy(busy_w[1]),
        .frame_count(fc_w[1]), .dbg_state(st_w[1]));

    tlp_tx_arbiter #(.N_REQ(N), .GAP(3), .IDLE_BYTE(IDLE_B)) dut_g3 (
        .clk(clk), .reset(reset), .req(req), .tlp_body(tlp_body),
        .gnt(gnt_w[2]), .data_out(data_w[2]), .data_k(k_w[2]), .busy(busy_w[2]),
        .frame_count(fc_w[2]), .dbg_state(st_w[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: position within the current frame ----------------
    int         m_pos  [NI];
    int         m_win  [NI];
    int         m_fc   [NI];
    int         m_ptr  [NI];
    logic [7:0] m_body [NI][NB];
    bit         m_live = 1'b0;
    int         mw;

    function automatic int gap_of(input int m);
        return (m == 0) ? 1 : (m == 1) ? 0 : 3;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef TLP_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int i = 1; i <= N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < NI; m++) begin
            if (reset) begin
                m_pos[m] = -1;
                m_fc[m]  = 0;
                m_ptr[m] = N - 1;
            end else if (m_pos[m] < 0) begin
                mw = pick(req, m_ptr[m]);
                if (mw >= 0) begin
                    m_pos[m] = 0;
                    m_win[m] = mw;
                    m_ptr[m] = mw;
                    for (int k = 0; k < NB; k++) m_body[m][k] = tlp_body[(mw*NB + k)*8 +: 8];
                end
            end else begin
                if (m_pos[m] == NB + 1) m_fc[m] = (m_fc[m] + 1) % 16;
                m_pos[m]++;
                if (m_pos[m] == NB + 2 + gap_of(m)) m_pos[m] = -1;
            end
        end
        if (reset) m_live = 1'b1;
    end

    // {gnt, data, k, busy, frame_count}
    function automatic logic [17:0] exp_vec(input int m);
        logic [3:0] g;
        logic [7:0] d;
        logic       k, b;
        int         p;
        p = m_pos[m];
        g = '0; d = IDLE_B; k = 1'b0; b = 1'b1;
        if (p < 0)              b = 1'b0;
        else if (p == 0)        begin g = 4'(1 << m_win[m]); d = STP; k = 1'b1; end
        else if (p <= NB)       d = m_body[m][p-1];
        else if (p == NB + 1)   begin d = END; k = 1'b1; end
        return {g, d, k, b, 4'(m_fc[m])};
    endfunction

    function automatic logic [17:0] act_vec(input int m);
        return {gnt_w[m], data_w[m], k_w[m], busy_w[m], fc_w[m]};
    endfunction

    // ---------------- per-cycle compare and monitors ----------------
    int g_log[$];
    int cyc = 0;
    int last_end [NI] = '{-1, -1, -1};
    int sp       [NI] = '{-1, -1, -1};
    int end_cnt0 = 0;
    bit saw_wrap = 1'b0;
    logic [3:0] fc0_prev = '0;

    always @(negedge clk) begin
        cyc++;
        if (m_live) begin
            for (int m = 0; m < NI; m++) begin
                check($sformatf("lane%0d", m), 32'(act_vec(m)), 32'(exp_vec(m)));
                if (k_w[m] && data_w[m] == END) last_end[m] = cyc;
                if (k_w[m] && data_w[m] == STP && last_end[m] >= 0) sp[m] = cyc - last_end[m];
            end
            if (gnt_w[0] != '0) begin
                check("gnt_onehot", $countones(gnt_w[0]), 1);
                for (int i = 0; i < N; i++) if (gnt_w[0][i]) g_log.push_back(i);
            end
            if (k_w[0] && data_w[0] == END) end_cnt0++;
            if (fc0_prev == 4'd15 && fc_w[0] == 4'd0) saw_wrap = 1'b1;
            fc0_prev = fc_w[0];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic set_seq_body(input int r);
        for (int k = 0; k < NB; k++) tlp_body[(r*NB + k)*8 +: 8] = 8'(k + 1);
    endtask

    task automatic randomize_bodies();
        for (int i = 0; i < N*NB; i++) tlp_body[i*8 +: 8] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_grants(input int n);
        int start;
        int t;
        start = g_log.size();
        t     = 0;
        while (g_log.size() < start + n && t < 30*n + 50) begin
            tick();
            t++;
        end
        check("grant_budget", 32'(g_log.size() >= start + n), 1);
    endtask

    task automatic check_order(input string name, input int exp[8], input int cnt);
        for (int i = 0; i < cnt; i++)
            check($sformatf("%s[%0d]", name, i), (g_log.size() > i) ? g_log[i] : -1, exp[i]);
    endtask

    initial begin
        int exp_all[8];
        int exp_1010[8];
        int ends_before;
`ifdef TLP_ARB_FIXED_PRIO_EN
        exp_all  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_1010 = '{1, 1, 1, 1, 0, 0, 0, 0};
`else
        exp_all  = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_1010 = '{1, 3, 1, 3, 0, 0, 0, 0};
`endif
        // reset state
        tick(2);
        check("rst_data", data_w[0], IDLE_B);
        check("rst_k", k_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        check("rst_gnt", gnt_w[0], 0);
        check("rst_fc", fc_w[0], 0);
        reset = 1'b0;

        // single request, body 01..12; body scrambled after grant must not leak
        randomize_bodies();
        set_seq_body(0);
        req = 4'b0001;
        tick();
        check("t1_gnt", gnt_w[0], 4'b0001);
        check("t1_stp", {k_w[0], data_w[0]}, {1'b1, STP});
        req = '0;
        for (int k = 0; k < NB; k++) tlp_body[k*8 +: 8] = 8'($urandom_range(128, 255));
        for (int k = 0; k < NB; k++) begin
            tick();
            check($sformatf("t1_byte%0d", k), {k_w[0], data_w[0]}, {1'b0, 8'(k + 1)});
        end
        tick();
        check("t1_end", {k_w[0], data_w[0]}, {1'b1, END});
        check("t1_fc_before", fc_w[0], 0);
        tick();
        check("t1_fc_after", fc_w[0], 1);
        check("t1_gap_busy", busy_w[0], 1);
        check("t1_gap_data", data_w[0], IDLE_B);
        tick();
        check("t1_idle_busy", busy_w[0], 0);
        tick(10);

        // all requesters high for 8 frames
        do_reset();
        randomize_bodies();
        g_log.delete();
        req = 4'b1111;
        run_grants(8);
        req = '0;
        tick(30);
        check("all_fc", fc_w[0], 8);
        check("all_ngrants", g_log.size(), 8);
        check_order("all_order", exp_all, 8);
        check("space_gap1", sp[0], 3);
        check("space_gap0", sp[1], 2);
        check("space_gap3", sp[2], 5);

        // req=1010 held
        do_reset();
        randomize_bodies();
        g_log.delete();
        req = 4'b1010;
        run_grants(4);
        req = '0;
        tick(30);
        check_order("r1010_order", exp_1010, 4);

        // reset at body byte 7
        do_reset();
        randomize_bodies();
        set_seq_body(0);
        req = 4'b0001;
        tick();
        req = '0;
        tick(8);
        check("rst_mid_byte7", data_w[0], 8'h08);
        reset = 1'b1;
        ends_before = end_cnt0;
        tick();
        reset = 1'b0;
        check("rst_mid_idle", {k_w[0], data_w[0]}, {1'b0, IDLE_B});
        check("rst_mid_busy", busy_w[0], 0);
        check("rst_mid_fc", fc_w[0], 0);
        tick(15);
        check("rst_mid_no_end", end_cnt0 - ends_before, 0);
        req = 4'b1000;
        tick();
        check("rst_after_gnt", gnt_w[0], 4'b1000);
        check("rst_after_stp", data_w[0], STP);
        req = '0;
        tick(30);

        // 17 back-to-back frames: frame_count wraps
        do_reset();
        randomize_bodies();
        saw_wrap = 1'b0;
        g_log.delete();
        req = 4'b1111;
        run_grants(17);
        req = '0;
        tick(30);
        check("wrap_fc", fc_w[0], 1);
        check("wrap_seen", 32'(saw_wrap), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
